hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_ctrl_forward_sel.sv | 22 ++
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, forward-select codes and the load result-source code.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } hz_state_e;

    localparam logic [1:0] FWD_RF          = 2'b00;
    localparam logic [1:0] FWD_W           = 2'b01;
    localparam logic [1:0] FWD_M           = 2'b10;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_forward_sel.sv
// One ALU operand forward select. The M stage wins over W because it holds
// the younger write to the same register.
module forward_sel
    import hazard_pkg::*;
(
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (RegWriteM && (RdM != 5'd0) && (RdM == RsE))
            sel = FWD_M;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE))
            sel = FWD_W;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use bubble, branch flush and
// memory-wait stall with timeout. Define HAZARD_PERF_CNT_EN for the stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             RegWriteM,
    input  logic [4:0]       RdM,
    input  logic             RegWriteW,
    input  logic [4:0]       RdW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    hz_state_e         state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic [1:0]        fwd_a, fwd_b;
    logic              lw_stall, mem_stall, hold;

    forward_sel u_fwd_a (
        .RsE(Rs1E), .RdM(RdM), .RegWriteM(RegWriteM),
        .RdW(RdW), .RegWriteW(RegWriteW), .sel(fwd_a)
    );
    forward_sel u_fwd_b (
        .RsE(Rs2E), .RdM(RdM), .RegWriteM(RegWriteM),
        .RdW(RdW), .RegWriteW(RegWriteW), .sel(fwd_b)
    );

    assign lw_stall  = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_stall = MemReqM && !MemReadyM;
    assign hold      = mem_stall || (state == ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Wait counter counts WAIT cycles; ERR once TIMEOUT of them pass unanswered.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt = WAIT;
                    wcnt_nxt  = '0;
                end
            end
            WAIT: begin
                wcnt_nxt = wcnt + WCNT_W'(1);
                if (MemReadyM)
                    state_nxt = RUN;
                else if (wcnt == WCNT_LAST)
                    state_nxt = ERR;
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = RUN;
        endcase
    end

    assign mem_timeout = (state == ERR);

    // A held pipeline keeps the branch in E, so PCSrcE is naturally deferred.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (rst_n) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (hold) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (StallF && !(&stall_cycles))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (FlushE && !(&flush_events))
                flush_events <= flush_events + CNT_W'(1);
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (TIMEOUT=4, CNT_W=2); expected outputs are
// queued as each step is driven and compared once the DUT settles.
module tb_hazard_ctrl;

    localparam int CNT_W = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .RdM(RdM), .RegWriteW(RegWriteW), .RdW(RdW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [10:0] v;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;
    logic [10:0] obs;

    assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE,
                  ForwardAE, ForwardBE, mem_timeout};

    // {StallF,D,E,M}, {FlushD,E}, ForwardAE, ForwardBE, mem_timeout
    function automatic logic [10:0] ex(input logic [3:0] st, input logic [1:0] fl,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic mt);
        return {st, fl, fa, fb, mt};
    endfunction

    task automatic quiet();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic expect_out(input string tag, input logic [10:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic check_now();
        exp_t e;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%b required=entry", obs);
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (obs === e.v) else begin
            failures++;
            $error("FAIL %s observed=%b required=%b", e.tag, obs, e.v);
        end
        checks++;
        assert (stall_cycles === m_stall && flush_events === m_flush) else begin
            failures++;
            $error("FAIL %s_cnt observed=%0d/%0d required=%0d/%0d", e.tag,
                   stall_cycles, flush_events, m_stall, m_flush);
        end
`ifdef HAZARD_PERF_CNT_EN
        if (rst_n && e.v[10] && m_stall != '1) m_stall++;
        if (rst_n && e.v[5]  && m_flush != '1) m_flush++;
`endif
    endtask

    task automatic step();
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit done;
        quiet();
        rst_n = 1'b0;
        // Busy inputs during reset must not leak to any output.
        Rs1D = 7; RdE = 7; ResultSrcE = 2'b01; PCSrcE = 1; MemReqM = 1;
        RegWriteM = 1; RdM = 5; Rs1E = 5;
        @(posedge clk); #1;
        expect_out("reset", ex(4'b0000, 2'b00, 2'b00, 2'b00, 0)); step();

        rst_n = 1'b1; quiet();
        expect_out("idle", ex(4'b0000, 2'b00, 2'b00, 2'b00, 0)); step();

        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5;
        expect_out("fwd_m_pri", ex(4'b0000, 2'b00, 2'b10, 2'b00, 0)); step();
        RdM = 0;
        expect_out("fwd_rdm0", ex(4'b0000, 2'b00, 2'b01, 2'b00, 0)); step();
        quiet(); RegWriteM = 0; RdM = 5; RegWriteW = 1; RdW = 9; Rs1E = 5; Rs2E = 9;
        expect_out("fwd_w_b", ex(4'b0000, 2'b00, 2'b00, 2'b01, 0)); step();
        quiet(); RegWriteM = 1; RdM = 3; RegWriteW = 1; RdW = 3; Rs2E = 3;
        expect_out("fwd_m_b", ex(4'b0000, 2'b00, 2'b00, 2'b10, 0)); step();

        quiet(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        expect_out("lw_stall", ex(4'b1100, 2'b01, 2'b00, 2'b00, 0)); step();
        quiet();
        expect_out("lw_bubble", ex(4'b0000, 2'b00, 2'b00, 2'b00, 0)); step();
        ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
        expect_out("lw_rd0", ex(4'b0000, 2'b00, 2'b00, 2'b00, 0)); step();
        quiet(); ResultSrcE = 2'b10; RdE = 7; Rs1D = 7;
        expect_out("lw_notload", ex(4'b0000, 2'b00, 2'b00, 2'b00, 0)); step();

        quiet(); ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; PCSrcE = 1;
        expect_out("branch_pri", ex(4'b0000, 2'b11, 2'b00, 2'b00, 0)); step();

        // Memory wait with a pending branch and load-use; forwarding stays live.
        MemReqM = 1; MemReadyM = 0; RegWriteM = 1; RdM = 4; Rs1E = 4;
        for (int i = 0; i < 3; i++) begin
            expect_out("mem_wait", ex(4'b1111, 2'b00, 2'b10, 2'b00, 0)); step();
        end
        MemReadyM = 1;
        expect_out("mem_release", ex(4'b0000, 2'b11, 2'b10, 2'b00, 0)); step();
        quiet();
        for (int i = 0; i < 6; i++) begin
            expect_out("back_in_run", ex(4'b0000, 2'b00, 2'b00, 2'b00, 0)); step();
        end

        // Reset in WAIT: without it the FSM would time out during the idle run.
        MemReqM = 1;
        expect_out("wait_enter", ex(4'b1111, 2'b00, 2'b00, 2'b00, 0)); step();
        MemReqM = 0;
        expect_out("wait_noreq", ex(4'b0000, 2'b00, 2'b00, 2'b00, 0)); step();
        rst_n = 1'b0; m_stall = '0; m_flush = '0; #1;
        expect_out("rst_in_wait", ex(4'b0000, 2'b00, 2'b00, 2'b00, 0)); check_now();
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_out("after_wait_rst", ex(4'b0000, 2'b00, 2'b00, 2'b00, 0)); step();
        end

        // Timeout: poll with a bounded budget for entry into ERR.
        MemReqM = 1; MemReadyM = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (mem_timeout) done = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
            if (m_stall != '1) m_stall++;
`endif
            @(posedge clk); #1;
        end
        checks++;
        assert (done) else begin
            failures++;
            $error("FAIL timeout_entry observed=%b required=1", mem_timeout);
        end
        MemReqM = 0; MemReadyM = 1; RegWriteW = 1; RdW = 6; Rs2E = 6;
        expect_out("err_sticky", ex(4'b1111, 2'b00, 2'b00, 2'b01, 1)); step();
        PCSrcE = 1;
        expect_out("err_noflush", ex(4'b1111, 2'b00, 2'b00, 2'b01, 1)); step();
        rst_n = 1'b0; m_stall = '0; m_flush = '0; #1;
        expect_out("rst_in_err", ex(4'b0000, 2'b00, 2'b00, 2'b00, 0)); check_now();
        @(posedge clk); #1; rst_n = 1'b1; quiet();
        expect_out("after_err_rst", ex(4'b0000, 2'b00, 2'b00, 2'b00, 0)); step();
        expect_out("after_err_rst2", ex(4'b0000, 2'b00, 2'b00, 2'b00, 0)); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
